ram_rd_ctrl: RTL



---
 rtl/ram_rd_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ram_rd_ctrl.sv
// rtl/ram_rd_ctrl.sv - two-pass spectrum RAM reader: peak search, then thresholded bin count and span
//
// Purpose:
//   Waits for the rising edge of the writer's completion flag, then scans the
//   spectrum RAM twice. Pass 1 finds the peak magnitude and the index of its
//   first occurrence. Pass 2 counts the bins at or above peak >> TH_SHIFT and
//   records their farthest distance from the carrier bin.
//
// Ports:
//   clk       system/FFT clock
//   rst       synchronous reset, active-high; aborts a run without a done pulse
//   start     writer completion flag (level); a run starts on its rising edge
//   rd_data   RAM read data, valid RD_LAT cycles after rd_en
//   rd_en     RAM read enable (registered)
//   rd_addr   RAM read address (registered), 0..NUM_BINS-1
//   busy      high from run start until done
//   done      one-cycle pulse when the results are valid
//   peak_mag  maximum magnitude
//   peak_idx  index of the first occurrence of the maximum
//   bin_cnt   number of bins with magnitude >= threshold
//   span      max |idx - CENTER_BIN| over the counted bins
module ram_rd_ctrl #(
  parameter int NUM_BINS   = 200,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int CENTER_BIN = 100,
  parameter int TH_SHIFT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] peak_mag,
  output logic [ADDR_W-1:0] peak_idx,
  output logic [ADDR_W:0]   bin_cnt,
  output logic [ADDR_W-1:0] span
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PASS1  = 3'd1;
  localparam logic [2:0] S_DRAIN1 = 3'd2;
  localparam logic [2:0] S_CALC   = 3'd3;
  localparam logic [2:0] S_PASS2  = 3'd4;
  localparam logic [2:0] S_DRAIN2 = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BINS - 1);
  localparam logic [ADDR_W-1:0] CENTER    = ADDR_W'(CENTER_BIN);
  localparam logic [1:0]        LAT_LAST  = 2'(RD_LAT - 1);

  logic [2:0]        state;
  logic              start_d;
  logic [1:0]        lat_cnt;
  logic [DATA_W-1:0] threshold;

  // Valid/index pipelines matching the RAM latency: the last stage tags the
  // sample currently present on rd_data.
  logic [RD_LAT-1:0] vld_pipe;
  logic [ADDR_W-1:0] idx_pipe [RD_LAT];

  logic              trigger;
  logic              samp_vld;
  logic [ADDR_W-1:0] samp_idx;
  logic [ADDR_W-1:0] offset;

  assign trigger  = start & ~start_d;
  assign samp_vld = vld_pipe[RD_LAT-1];
  assign samp_idx = idx_pipe[RD_LAT-1];

  // Distance from the carrier bin, ordered so the subtraction never wraps.
  always_comb begin
    offset = '0;
    if (samp_idx >= CENTER) offset = samp_idx - CENTER;
    else                    offset = CENTER - samp_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      start_d   <= 1'b0;
      lat_cnt   <= '0;
      threshold <= '0;
      vld_pipe  <= '0;
      for (int i = 0; i < RD_LAT; i++) idx_pipe[i] <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      peak_mag  <= '0;
      peak_idx  <= '0;
      bin_cnt   <= '0;
      span      <= '0;
    end else begin
      start_d <= start;
      done    <= 1'b0;

      vld_pipe[0] <= rd_en;
      idx_pipe[0] <= rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end

      // Returning samples: pass 1 data lands in PASS1/DRAIN1, pass 2 data in
      // PASS2/DRAIN2, because each drain lasts exactly the read latency.
      if (samp_vld) begin
        if (state == S_PASS1 || state == S_DRAIN1) begin
          // Strict compare keeps the lowest index on ties.
          if (rd_data > peak_mag) begin
            peak_mag <= rd_data;
            peak_idx <= samp_idx;
          end
        end else if (state == S_PASS2 || state == S_DRAIN2) begin
          if (rd_data >= threshold) begin
            bin_cnt <= bin_cnt + 1'b1;
            if (offset > span) span <= offset;
          end
        end
      end

      case (state)
        S_IDLE: begin
          if (trigger) begin
            state    <= S_PASS1;
            busy     <= 1'b1;
            rd_en    <= 1'b1;
            rd_addr  <= '0;
            peak_mag <= '0;
            peak_idx <= '0;
            bin_cnt  <= '0;
            span     <= '0;
          end
        end
        S_PASS1: begin
          if (rd_addr == LAST_ADDR) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
            state   <= S_DRAIN1;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        S_DRAIN1: begin
          if (lat_cnt == LAT_LAST) begin
            lat_cnt <= '0;
            state   <= S_CALC;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_CALC: begin
          threshold <= peak_mag >> TH_SHIFT;
          if (peak_mag == '0) begin
            // Nothing to threshold against: skip the second scan.
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state   <= S_PASS2;
            rd_en   <= 1'b1;
            rd_addr <= '0;
          end
        end
        S_PASS2: begin
          if (rd_addr == LAST_ADDR) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
            state   <= S_DRAIN2;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        S_DRAIN2: begin
          if (lat_cnt == LAT_LAST) begin
            lat_cnt <= '0;
            state   <= S_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
